// File: rtl/dual_port_sram_param.sv
`default_nettype none
// ============================================================================
//  Module   : dual_port_sram_param
//  Purpose  : Parametrised true dual-port synchronous SRAM, single clock.
//             Per-byte write enables, 1- or 2-cycle read latency, selectable
//             same-port read-during-write behaviour, deterministic
//             write-write collision resolution (port A wins per byte) with a
//             saturating collision counter, and an optional clear-on-reset
//             sequencer that zeroes every word after reset.
//  Ports    : Clk_In / Reset_In        - clock, synchronous active-high reset
//             Port_{A,B}_Data_In       - write data
//             Port_{A,B}_Address_In    - word address
//             Port_{A,B}_Byte_Enable   - byte write mask
//             Port_{A,B}_Write_Enable  - write request
//             Port_{A,B}_Read_Enable   - read request
//             Port_{A,B}_Data_Out      - read data (holds when not valid)
//             Port_{A,B}_Data_Valid    - one-cycle pulse per read request
//             Init_Busy                - clear sequencer running
//             Collision_Pulse          - write-write collision seen last edge
//             Collision_Count          - saturating collision count
//  Revision : 1.0 - initial release
// ============================================================================
module dual_port_sram_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    Clk_In,
    input  logic                    Reset_In,
    input  logic [DATA_WIDTH-1:0]   Port_A_Data_In,
    input  logic [ADDR_WIDTH-1:0]   Port_A_Address_In,
    input  logic [DATA_WIDTH/8-1:0] Port_A_Byte_Enable,
    input  logic                    Port_A_Write_Enable,
    input  logic                    Port_A_Read_Enable,
    output logic [DATA_WIDTH-1:0]   Port_A_Data_Out,
    output logic                    Port_A_Data_Valid,
    input  logic [DATA_WIDTH-1:0]   Port_B_Data_In,
    input  logic [ADDR_WIDTH-1:0]   Port_B_Address_In,
    input  logic [DATA_WIDTH/8-1:0] Port_B_Byte_Enable,
    input  logic                    Port_B_Write_Enable,
    input  logic                    Port_B_Read_Enable,
    output logic [DATA_WIDTH-1:0]   Port_B_Data_Out,
    output logic                    Port_B_Data_Valid,
    output logic                    Init_Busy,
    output logic                    Collision_Pulse,
    output logic [15:0]             Collision_Count
);

    localparam int c_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int c_NBYTES = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic                   r_coll_pulse;
    logic [15:0]            r_coll_count;

    // Port-indexed views so both ports share one description of the read path
    logic [DATA_WIDTH-1:0]  w_din  [2];
    logic [ADDR_WIDTH-1:0]  w_addr [2];
    logic [c_NBYTES-1:0]    w_be   [2];
    logic                   w_we   [2];
    logic                   w_re   [2];
    logic                   w_accept;
    logic                   w_clear;
    logic                   w_coll;

    // Requests are honoured only in RUN and never on a reset edge
    assign w_accept = (r_state == ST_RUN) && !Reset_In;
    assign w_clear  = (r_state == ST_INIT) && !Reset_In;

    assign w_din[0]  = Port_A_Data_In;
    assign w_din[1]  = Port_B_Data_In;
    assign w_addr[0] = Port_A_Address_In;
    assign w_addr[1] = Port_B_Address_In;
    assign w_be[0]   = Port_A_Byte_Enable;
    assign w_be[1]   = Port_B_Byte_Enable;
    // An all-zero byte mask is not a write, so it can never collide
    assign w_we[0]   = Port_A_Write_Enable && (|Port_A_Byte_Enable) && w_accept;
    assign w_we[1]   = Port_B_Write_Enable && (|Port_B_Byte_Enable) && w_accept;
    assign w_re[0]   = Port_A_Read_Enable && w_accept;
    assign w_re[1]   = Port_B_Read_Enable && w_accept;

    assign w_coll = w_we[0] && w_we[1] && (w_addr[0] == w_addr[1]);

    // ------------------------------------------------------------------------
    // Clear sequencer: walks every address once, leaving INIT after the last
    // word so Init_Busy is high for exactly DEPTH cycles after reset release.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    if (&r_ptr) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign Init_Busy = (r_state == ST_INIT);

    // ------------------------------------------------------------------------
    // Memory array (never reset). Port B bytes are written first and port A
    // bytes last, so on a same-address collision A's non-blocking update
    // overrides B only on the bytes both ports enable.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_In) begin
        if (w_clear) begin
            r_mem[r_ptr] <= '0;
        end
        for (int i = 0; i < c_NBYTES; i++) begin
            if (w_we[1] && w_be[1][i]) begin
                r_mem[w_addr[1]][8*i +: 8] <= w_din[1][8*i +: 8];
            end
            if (w_we[0] && w_be[0][i]) begin
                r_mem[w_addr[0]][8*i +: 8] <= w_din[0][8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read paths
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] w_rd_word;
        logic [DATA_WIDTH-1:0] w_pipe_data;
        logic                  w_pipe_vld;
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_dvld;

        // The array read sees the pre-edge contents, i.e. the old word. In
        // write-first mode only this port's own enabled bytes are merged in;
        // a write from the other port never shows through.
        always_comb begin
            w_rd_word = r_mem[w_addr[p]];
            if (RDW_MODE == 1) begin
                for (int i = 0; i < c_NBYTES; i++) begin
                    if (w_we[p] && w_be[p][i]) begin
                        w_rd_word[8*i +: 8] = w_din[p][8*i +: 8];
                    end
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s1_vld;
            logic [DATA_WIDTH-1:0] r_s1_data;

            always_ff @(posedge Clk_In) begin
                if (Reset_In) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= '0;
                end else begin
                    r_s1_vld <= w_re[p];
                    if (w_re[p]) begin
                        r_s1_data <= w_rd_word;
                    end
                end
            end

            assign w_pipe_vld  = r_s1_vld;
            assign w_pipe_data = r_s1_data;
        end else begin : g_lat1
            assign w_pipe_vld  = w_re[p];
            assign w_pipe_data = w_rd_word;
        end

        // Output register holds its value between valid pulses
        always_ff @(posedge Clk_In) begin
            if (Reset_In) begin
                r_dout <= '0;
                r_dvld <= 1'b0;
            end else begin
                r_dvld <= w_pipe_vld;
                if (w_pipe_vld) begin
                    r_dout <= w_pipe_data;
                end
            end
        end
    end

    assign Port_A_Data_Out   = g_port[0].r_dout;
    assign Port_A_Data_Valid = g_port[0].r_dvld;
    assign Port_B_Data_Out   = g_port[1].r_dout;
    assign Port_B_Data_Valid = g_port[1].r_dvld;

    // ------------------------------------------------------------------------
    // Collision reporting
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_coll_pulse <= 1'b0;
            r_coll_count <= '0;
        end else begin
            r_coll_pulse <= w_coll;
            if (w_coll && (r_coll_count != 16'hFFFF)) begin
                r_coll_count <= r_coll_count + 16'd1;
            end
        end
    end

    assign Collision_Pulse = r_coll_pulse;
    assign Collision_Count = r_coll_count;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_sram_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dual_port_sram_param
//  Purpose  : Self-checking bench for dual_port_sram_param. Two instances
//             share one stimulus stream: instance 0 uses latency 1 and
//             read-first, instance 1 uses latency 2 and write-first.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_sram_param;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] a_d, b_d;
    logic [AW-1:0] a_ad, b_ad;
    logic [NB-1:0] a_be, b_be;
    logic          a_we, a_re, b_we, b_re;

    // Streams: 0 = inst0 A, 1 = inst0 B, 2 = inst1 A, 3 = inst1 B
    logic [DW-1:0] w_dout  [4];
    logic          w_dval  [4];
    logic          w_busy  [2];
    logic          w_pulse [2];
    logic [15:0]   w_cnt   [2];

    dual_port_sram_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .Clk_In(clk), .Reset_In(rst),
        .Port_A_Data_In(a_d), .Port_A_Address_In(a_ad), .Port_A_Byte_Enable(a_be),
        .Port_A_Write_Enable(a_we), .Port_A_Read_Enable(a_re),
        .Port_A_Data_Out(w_dout[0]), .Port_A_Data_Valid(w_dval[0]),
        .Port_B_Data_In(b_d), .Port_B_Address_In(b_ad), .Port_B_Byte_Enable(b_be),
        .Port_B_Write_Enable(b_we), .Port_B_Read_Enable(b_re),
        .Port_B_Data_Out(w_dout[1]), .Port_B_Data_Valid(w_dval[1]),
        .Init_Busy(w_busy[0]), .Collision_Pulse(w_pulse[0]), .Collision_Count(w_cnt[0])
    );

    dual_port_sram_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
        .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .Clk_In(clk), .Reset_In(rst),
        .Port_A_Data_In(a_d), .Port_A_Address_In(a_ad), .Port_A_Byte_Enable(a_be),
        .Port_A_Write_Enable(a_we), .Port_A_Read_Enable(a_re),
        .Port_A_Data_Out(w_dout[2]), .Port_A_Data_Valid(w_dval[2]),
        .Port_B_Data_In(b_d), .Port_B_Address_In(b_ad), .Port_B_Byte_Enable(b_be),
        .Port_B_Write_Enable(b_we), .Port_B_Read_Enable(b_re),
        .Port_B_Data_Out(w_dout[3]), .Port_B_Data_Valid(w_dval[3]),
        .Init_Busy(w_busy[1]), .Collision_Pulse(w_pulse[1]), .Collision_Count(w_cnt[1])
    );

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    int            init_left;
    int            cyc = 0;
    exp_t          exp_q [4][$];
    int            pulse_q [$];
    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents data
    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (w_dval[s] === 1'b1) begin
                if (exp_q[s].size() == 0) begin
                    chk($sformatf("spurious_valid_s%0d", s), 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[s].pop_front();
                    chk($sformatf("valid_cycle_s%0d", s), 32'(cyc), 32'(mon_e.due));
                    chk($sformatf("rdata_s%0d", s), w_dout[s], mon_e.data);
                end
            end else if (exp_q[s].size() > 0 && exp_q[s][0].due < cyc) begin
                mon_e = exp_q[s].pop_front();
                chk($sformatf("missing_valid_s%0d", s), 32'd0, 32'd1);
            end
        end
        if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
            void'(pulse_q.pop_front());
            chk("coll_pulse_i0", 32'(w_pulse[0]), 32'd1);
            chk("coll_pulse_i1", 32'(w_pulse[1]), 32'd1);
        end else begin
            if (w_pulse[0] !== 1'b0) chk("coll_pulse_i0", 32'(w_pulse[0]), 32'd0);
            if (w_pulse[1] !== 1'b0) chk("coll_pulse_i1", 32'(w_pulse[1]), 32'd0);
        end
    end

    // One clock of stimulus; expectations derived from the model memory
    task automatic drive(input logic awe, input logic are, input logic [AW-1:0] aad,
                         input logic [DW-1:0] ad, input logic [NB-1:0] abe,
                         input logic bwe, input logic bre, input logic [AW-1:0] bad,
                         input logic [DW-1:0] bd, input logic [NB-1:0] bbe);
        logic [DW-1:0] olda, oldb;
        logic          aw, bw;
        rst = 1'b0;
        a_we = awe; a_re = are; a_ad = aad; a_d = ad; a_be = abe;
        b_we = bwe; b_re = bre; b_ad = bad; b_d = bd; b_be = bbe;
        chk("init_busy_i0", 32'(w_busy[0]), 32'(init_left > 0));
        chk("init_busy_i1", 32'(w_busy[1]), 32'(init_left > 0));
        chk("coll_count_i0", 32'(w_cnt[0]), 32'(m_cnt));
        chk("coll_count_i1", 32'(w_cnt[1]), 32'(m_cnt));
        if (init_left > 0) begin
            init_left--;
        end else begin
            olda = m_mem[aad];
            oldb = m_mem[bad];
            aw = awe && (abe != '0);
            bw = bwe && (bbe != '0);
            if (are) begin
                exp_q[0].push_back('{cyc + 1, olda});
                exp_q[2].push_back('{cyc + 2, aw ? merge(olda, ad, abe) : olda});
            end
            if (bre) begin
                exp_q[1].push_back('{cyc + 1, oldb});
                exp_q[3].push_back('{cyc + 2, bw ? merge(oldb, bd, bbe) : oldb});
            end
            if (bw) m_mem[bad] = merge(m_mem[bad], bd, bbe);
            if (aw) m_mem[aad] = merge(m_mem[aad], ad, abe);
            if (aw && bw && aad == bad) begin
                if (m_cnt < 65535) m_cnt++;
                pulse_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        a_we = 0; a_re = 0; b_we = 0; b_re = 0;
        // Anything due after the reset edge is flushed by the reset
        for (int s = 0; s < 4; s++)
            while (exp_q[s].size() > 0 && exp_q[s][exp_q[s].size()-1].due > cyc)
                void'(exp_q[s].pop_back());
        while (pulse_q.size() > 0 && pulse_q[pulse_q.size()-1] > cyc)
            void'(pulse_q.pop_back());
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cnt     = 0;
        init_left = DEPTH;
        repeat (n) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("rst_dout_s%0d", s), w_dout[s], 32'd0);
            chk($sformatf("rst_dval_s%0d", s), 32'(w_dval[s]), 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_count_i%0d", k), 32'(w_cnt[k]), 32'd0);
            chk($sformatf("rst_busy_i%0d", k), 32'(w_busy[k]), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_we = 0; a_re = 0; a_ad = '0; a_d = '0; a_be = '0;
        b_we = 0; b_re = 0; b_ad = '0; b_d = '0; b_be = '0;
        m_cnt = 0;
        init_left = DEPTH;
        repeat (2) @(posedge clk);
        #1;

        // 1: clear sequence; write during INIT must be ignored
        do_reset(2);
        drive(1, 0, 8'h10, 32'h5555_AAAA, 4'hF, 0, 0, '0, '0, '0);
        idle(DEPTH - 1);
        drive(1'b0, 1'b1, 8'h00, '0, '0, 1'b0, 1'b1, 8'h10, '0, '0);
        drive(1'b0, 1'b1, 8'hFF, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        idle(3);

        // 2: byte-enabled partial write, cross-port read
        drive(1, 0, 8'h05, 32'hDEAD_BEEF, 4'hF, 0, 0, '0, '0, '0);
        drive(1, 0, 8'h05, 32'h1122_3344, 4'b0101, 0, 0, '0, '0, '0);
        drive(0, 0, '0, '0, '0, 0, 1, 8'h05, '0, '0);
        idle(3);

        // 3: write-write collision with overlapping byte masks
        drive(1, 0, 8'h20, 32'hAAAA_AAAA, 4'b0011, 1, 0, 8'h20, 32'hBBBB_BBBB, 4'b0110);
        drive(0, 1, 8'h20, '0, '0, 0, 0, '0, '0, '0);
        idle(3);

        // 4: same-port and cross-port read-during-write
        drive(1, 0, 8'h30, 32'h1234_5678, 4'hF, 0, 0, '0, '0, '0);
        drive(1, 1, 8'h30, 32'hCAFE_F00D, 4'hF, 0, 1, 8'h30, '0, '0);
        drive(0, 1, 8'h30, '0, '0, 0, 0, '0, '0, '0);
        idle(3);

        // 5: back-to-back reads, then reset mid-stream
        for (int i = 1; i <= 4; i++)
            drive(1, 0, 8'(i), 32'hA0A0_0000 + 32'(i), 4'hF, 0, 0, '0, '0, '0);
        for (int i = 1; i <= 4; i++)
            drive(0, 0, '0, '0, '0, 0, 1, 8'(i), '0, '0);
        idle(3);
        drive(0, 0, '0, '0, '0, 0, 1, 8'h01, '0, '0);
        drive(0, 0, '0, '0, '0, 0, 1, 8'h02, '0, '0);
        do_reset(1);
        idle(DEPTH);

        // Random traffic on a small address window to provoke hazards
        for (int i = 0; i < 3000; i++)
            drive(1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), $urandom, 4'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), $urandom, 4'($urandom));
        idle(4);

        // 6: counter saturation
        for (int i = 0; i < 65537; i++)
            drive(1, 0, 8'h40, $urandom, 4'hF, 1, 0, 8'h40, $urandom, 4'hF);
        idle(3);
        chk("sat_count_i0", 32'(w_cnt[0]), 32'h0000_FFFF);
        chk("sat_count_i1", 32'(w_cnt[1]), 32'h0000_FFFF);

        for (int s = 0; s < 4; s++)
            chk($sformatf("drain_s%0d", s), 32'(exp_q[s].size()), 32'd0);
        chk("drain_pulse", 32'(pulse_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
